// File: rtl/ll_flight_ctrl_if.sv
// Lander control bus: memory-unit quantities and keypad inputs toward the
// controller, and control outputs back toward memory, ALU and display.
//   master : controller side (ll_flight_ctrl)
//   slave  : surrounding datapath / keypad side
//   alt, vel     W-bit 10's-complement BCD altitude / velocity
//   key_strobe   synchronised key-held level; key_code 5-bit key encoding
//   wen          one-cycle memory write enable per simulation step
//   thrust       W-bit BCD thrust; disp_sel display quantity select
//   land, crash  touchdown outcome flags; state 0=READY 1=RUN 2=LANDED 3=CRASHED
interface ll_flight_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] alt;
  logic [W-1:0] vel;
  logic         key_strobe;
  logic [4:0]   key_code;
  logic         wen;
  logic [W-1:0] thrust;
  logic [1:0]   disp_sel;
  logic         land;
  logic         crash;
  logic [1:0]   state;

  modport master (
    input  alt, vel, key_strobe, key_code,
    output wen, thrust, disp_sel, land, crash, state
  );

  modport slave (
    output alt, vel, key_strobe, key_code,
    input  wen, thrust, disp_sel, land, crash, state
  );
endinterface

// File: rtl/ll_flight_ctrl.sv
// Lunar-lander control unit, generic over DIGITS BCD digits.
// Sequences game start, periodic write strobes, touchdown classification,
// thrust entry and display selection from the synchronised keypad.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : ll_flight_ctrl_if master modport (see interface for signals)
module ll_flight_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned TICK_DIV = 25,
  parameter logic [4*DIGITS-1:0] CRASH_VEL = 'h30,
  parameter logic [4*DIGITS-1:0] THRUST_INIT = 'h5
) (
  input logic clk,
  input logic rst,
  ll_flight_ctrl_if.master bus
);
  localparam int unsigned W = 4 * DIGITS;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  // Digit-serial BCD addition, carry out of the top digit discarded.
  function automatic logic [W-1:0] bcd_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic cin);
    logic [W-1:0] s;
    logic         c;
    logic [4:0]   d;
    s = '0;
    c = cin;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i+:4] = d[3:0];
    end
    return s;
  endfunction

  function automatic logic [W-1:0] bcd_nines(input logic [W-1:0] a);
    logic [W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      s[4*i+:4] = 4'd9 - a[4*i+:4];
    return s;
  endfunction

  // 10's complement of CRASH_VEL; BCD bit patterns order like their values,
  // so a plain unsigned compare against it classifies the descent speed.
  localparam logic [W-1:0] LIMIT = bcd_add(bcd_nines(CRASH_VEL), '0, 1'b1);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    RUN     = 2'd1,
    LANDED  = 2'd2,
    CRASHED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  thrust_q, thrust_d;
  logic [1:0]    disp_q, disp_d;
  logic          land_q, land_d;
  logic          crash_q, crash_d;
  logic          key_q;

  logic          key_evt;
  logic          is_digit;
  logic          is_disp;
  logic          wen;
  logic [W-1:0]  sum;
  logic          touchdown;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= READY;
      cnt_q    <= '0;
      thrust_q <= THRUST_INIT;
      disp_q   <= '0;
      land_q   <= 1'b0;
      crash_q  <= 1'b0;
      key_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thrust_q <= thrust_d;
      disp_q   <= disp_d;
      land_q   <= land_d;
      crash_q  <= crash_d;
      key_q    <= bus.key_strobe;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    thrust_d = thrust_q;
    disp_d   = disp_q;
    land_d   = land_q;
    crash_d  = crash_q;

    key_evt   = bus.key_strobe && !key_q;
    is_digit  = bus.key_code < 5'd10;
    is_disp   = bus.key_code[4:2] == 3'b100;
    wen       = (state_q == RUN) && (cnt_q == CNT_LAST);
    sum       = bcd_add(bus.alt, bus.vel, 1'b0);
    touchdown = (sum == '0) || (sum[W-1:W-4] >= 4'd5);

    // 16(W)..19(Z) map to 3..0, i.e. the inverted low two code bits.
    if (key_evt && is_disp)
      disp_d = ~bus.key_code[1:0];

    unique case (state_q)
      READY: begin
        cnt_d = '0;
        if (key_evt && is_digit) begin
          state_d  = RUN;
          thrust_d = '0;
          thrust_d[3:0] = bus.key_code[3:0];
        end
      end
      RUN: begin
        cnt_d = wen ? '0 : cnt_q + 1'b1;
        if (key_evt && is_digit) begin
          thrust_d = '0;
          thrust_d[3:0] = bus.key_code[3:0];
        end
        if (wen && touchdown) begin
          if (bus.vel < LIMIT) begin
            state_d = CRASHED;
            crash_d = 1'b1;
          end else begin
            state_d = LANDED;
            land_d  = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.wen      = wen;
  assign bus.thrust   = thrust_q;
  assign bus.disp_sel = disp_q;
  assign bus.land     = land_q;
  assign bus.crash    = crash_q;
  assign bus.state    = state_q;
endmodule

// File: doc/ll_flight_ctrl.md
Name: ll_flight_ctrl

Overview:
Parametrised control unit for the lunar-lander datapath. It replaces the fixed-width control block with one generalised to DIGITS BCD digits and a programmable step rate. It sequences game start, periodic state-update strobes (wen), touchdown classification (land vs crash), thrust entry and display selection from the synchronised keypad. It sits between the keypad synchroniser and the memory/ALU/display units; all lander quantities are 10's-complement BCD.

Parameters:
DIGITS, 4, number of BCD digits per quantity; W = 4*DIGITS bits.
TICK_DIV, 25, clk cycles per simulation step; must be >= 1.
CRASH_VEL, 'h30 (W bits, BCD), largest descent speed magnitude that still counts as a landing.
THRUST_INIT, 'h5 (W bits, BCD), thrust value after reset.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
alt  in  W  current altitude from memory unit (BCD, 10's complement)
vel  in  W  current velocity from memory unit (BCD, 10's complement; negative = descending)
key_strobe  in  1  synchronised key-pressed level (high while any key is held)
key_code  in  5  encoded key: 0-9 digits, 16=W, 17=X, 18=Y, 19=Z
wen  out  1  memory write enable, one-cycle pulse per step
thrust  out  W  thrust value to ALU/memory thrust_n
disp_sel  out  2  display quantity: 0=alt, 1=vel, 2=fuel, 3=thrust
land  out  1  high after a safe touchdown
crash  out  1  high after a crash touchdown
state  out  2  0=READY, 1=RUN, 2=LANDED, 3=CRASHED

Behaviour:
- Reset (async): state=READY, tick counter=0, thrust=THRUST_INIT, disp_sel=0, land=0, crash=0, internal key-edge register=0; wen=0.
- Key event: a one-cycle pulse on the clk edge where key_strobe is sampled 1 and was 0 on the previous edge. key_code is sampled on that same edge. Holding a key generates exactly one event. Codes 10-15 and 20-31 are ignored.
- Digit event (0-9): accepted only in READY or RUN. Loads thrust = zero-extended digit on the next edge. In READY it also moves to RUN and clears the counter. Ignored in LANDED/CRASHED.
- Display event (16-19): accepted in every state. 19(Z)->0, 18(Y)->1, 17(X)->2, 16(W)->3. Does not start the game.
- Tick counter: runs only in RUN, counting 0..TICK_DIV-1 and wrapping to 0. It holds at 0 in the other states.
- wen = (state==RUN) && (counter==TICK_DIV-1), decoded from registers only. This gives exactly one high cycle per TICK_DIV cycles. TICK_DIV=1 means wen is continuously high in RUN. wen=0 in READY/LANDED/CRASHED.
- Touchdown check: sum = alt + vel as DIGITS-digit BCD addition, carry discarded. Touchdown is true when sum==0 or the MS digit of sum >= 5.
  - The check is evaluated only on edges where wen=1, using the pre-update alt/vel.
- Classification at touchdown:
  - crash if vel (as unsigned BCD bits) < LIMIT, where LIMIT = 10^DIGITS - CRASH_VEL expressed in BCD. For DIGITS=4 and CRASH_VEL=30, LIMIT='h9970.
  - otherwise land. A velocity exactly at -CRASH_VEL is a landing.
- On a touchdown edge, state becomes LANDED (land<=1) or CRASHED (crash<=1). wen is still high for that edge, so memory stores the ALU's clamped zero values. After that, wen stays 0.
- LANDED/CRASHED are terminal. land and crash are mutually exclusive and hold until rst.
- Simultaneous digit event and wen edge: memory captures the old thrust; the new thrust applies from the next step.
- Reset mid-RUN: immediate return to READY with all reset values; any pending wen is cut off asynchronously.
- All BCD arithmetic and comparisons are DIGITS-generic. No binary conversion is allowed.

Test Plan:
(DIGITS=4, TICK_DIV=4, CRASH_VEL='h30)
- Reset then no keys for 100 cycles -> state=0, wen never 1, thrust='h0005, disp_sel=0, land=crash=0.
- Press key 7 (strobe high 10 cycles) -> one event only. Next edge: state=1, thrust='h0007. wen then pulses high 1 cycle in every 4, first pulse on the 4th cycle after RUN entry.
- In RUN, drive alt='h0020, vel='h9970 (-30) -> on the next wen edge: land=1, state=2, wen=0 thereafter. Key 3 then leaves thrust unchanged.
- Drive alt='h0020, vel='h9969 (-31) -> crash=1, state=3, land=0. Repeat with alt='h0040, vel='h9969 -> no touchdown (sum='h0009), stays RUN.
- Keys Z,Y,X,W in turn (also in READY and CRASHED) -> disp_sel=0,1,2,3. State is unchanged, and key 12 has no effect.
- Assert rst for 1 cycle mid-RUN coincident with a wen cycle -> wen drops immediately, state=0, thrust='h0005, counter=0. Re-run with DIGITS=6, CRASH_VEL='h50, vel='h999950 -> land.
